axi_rd_arbiter: RTL and testbench

- Shares one AXI4 read master port, one DRAM_NUMBER lane, between two requesters: client 0 is instruction fetch and client 1 is data load.
- Accepts a simple burst request from each client and issues one AR transaction at a time.
- Steers the returning R beats to the owning client.
- Sits inside CPU between the fetch/load units and the AXI read interface.

---
 rtl/axi_rd_arbiter.sv | 152 +++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// Two-client AXI4 read arbiter: fetch (client 0) and load (client 1) share one AR/R port,
// one burst outstanding at a time. Define RDARB_FIXED_PRIO_EN for fixed priority (fetch wins ties).
module axi_rd_arbiter #(
   parameter int ID_WIDTH   = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [1:0]              req,
   input  logic [2*ADDR_WIDTH-1:0] req_addr,
   input  logic [2*7-1:0]          req_len,
   output logic [1:0]              req_ack,
   output logic [1:0]              rsp_valid,
   output logic [DATA_WIDTH-1:0]   rsp_data,
   output logic                    rsp_last,
   output logic [ID_WIDTH-1:0]     arid_m_inf,
   output logic [ADDR_WIDTH-1:0]   araddr_m_inf,
   output logic [6:0]              arlen_m_inf,
   output logic [2:0]              arsize_m_inf,
   output logic [1:0]              arburst_m_inf,
   output logic                    arvalid_m_inf,
   input  logic                    arready_m_inf,
   input  logic [DATA_WIDTH-1:0]   rdata_m_inf,
   input  logic                    rlast_m_inf,
   input  logic                    rvalid_m_inf,
   output logic                    rready_m_inf
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADDR = 2'd1,
      S_DATA = 2'd2
   } state_e;

   state_e                  state_q, state_d;
   logic                    owner_q, owner_d;
   logic                    last_grant_q, last_grant_d;
   logic                    arvalid_q, arvalid_d;
   logic                    rready_q, rready_d;
   logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
   logic [6:0]              arlen_q, arlen_d;

   logic                    winner;
   logic                    ar_hs;
   logic                    r_done;

`ifdef RDARB_FIXED_PRIO_EN
   assign winner = ~req[0];
`else
   // Tie goes to whoever was not served last; a lone request always wins.
   assign winner = (&req) ? ~last_grant_q : req[1];
`endif

   assign ar_hs  = arvalid_q & arready_m_inf;
   assign r_done = (state_q == S_DATA) & rvalid_m_inf & rlast_m_inf;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         arvalid_q    <= 1'b0;
         rready_q     <= 1'b0;
         araddr_q     <= '0;
         arlen_q      <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         arvalid_q    <= arvalid_d;
         rready_q     <= rready_d;
         araddr_q     <= araddr_d;
         arlen_q      <= arlen_d;
      end
   end

   // NOTE: every variable gets a hold default first so no path through the case infers a latch.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      arvalid_d    = arvalid_q;
      rready_d     = rready_q;
      araddr_d     = araddr_q;
      arlen_d      = arlen_q;
      unique case (state_q)
         S_IDLE: begin
            if (|req) begin
               owner_d   = winner;
               araddr_d  = winner ? req_addr[ADDR_WIDTH +: ADDR_WIDTH] : req_addr[0 +: ADDR_WIDTH];
               arlen_d   = winner ? req_len[7 +: 7] : req_len[0 +: 7];
               arvalid_d = 1'b1;
               state_d   = S_ADDR;
            end
         end
         S_ADDR: begin
            if (ar_hs) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = S_DATA;
            end
         end
         S_DATA: begin
            if (r_done) begin
               rready_d = 1'b0;
               state_d  = S_IDLE;
`ifndef RDARB_FIXED_PRIO_EN
               last_grant_d = owner_q;
`endif
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // R channel is a zero-latency passthrough to the owner while a burst is in DATA.
   always_comb begin
      req_ack   = 2'b00;
      rsp_valid = 2'b00;
      rsp_last  = 1'b0;
      if (ar_hs) begin
         req_ack[owner_q] = 1'b1;
      end
      if (state_q == S_DATA) begin
         rsp_valid[owner_q] = rvalid_m_inf;
         rsp_last           = rlast_m_inf;
      end
   end

   assign rsp_data      = rdata_m_inf;
   assign arid_m_inf    = {{(ID_WIDTH-1){1'b0}}, owner_q};
   assign araddr_m_inf  = araddr_q;
   assign arlen_m_inf   = arlen_q;
   assign arsize_m_inf  = 3'b001;
   assign arburst_m_inf = 2'b01;
   assign arvalid_m_inf = arvalid_q;
   assign rready_m_inf  = rready_q;

   a_arvalid_in_addr : assert property (@(posedge clk) disable iff (!rst_n)
      arvalid_q |-> (state_q == S_ADDR));
   a_rready_in_data : assert property (@(posedge clk) disable iff (!rst_n)
      rready_q == (state_q == S_DATA));
   a_ar_stable : assert property (@(posedge clk) disable iff (!rst_n)
      (arvalid_q && !arready_m_inf) |=> (arvalid_q && $stable(araddr_q) && $stable(arlen_q)));
   a_rsp_onehot : assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(rsp_valid));

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: bench acts as both clients and the AXI slave,
// predicting grant order from a transaction-level arbitration model.
module tb_axi_rd_arbiter;
   localparam int IW = 4;
   localparam int AW = 32;
   localparam int DW = 16;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [1:0]      req;
   logic [2*AW-1:0] req_addr;
   logic [13:0]     req_len;
   logic [1:0]      req_ack;
   logic [1:0]      rsp_valid;
   logic [DW-1:0]   rsp_data;
   logic            rsp_last;
   logic [IW-1:0]   arid;
   logic [AW-1:0]   araddr;
   logic [6:0]      arlen;
   logic [2:0]      arsize;
   logic [1:0]      arburst;
   logic            arvalid;
   logic            arready;
   logic [DW-1:0]   rdata;
   logic            rlast;
   logic            rvalid;
   logic            rready;

   int n_checks = 0;
   int n_errors = 0;
   int model_last_grant;
   logic [AW-1:0] cl_addr [2];
   logic [6:0]    cl_len  [2];

   always #5 clk = ~clk;

   axi_rd_arbiter #(.ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_len(req_len),
      .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last),
      .arid_m_inf(arid), .araddr_m_inf(araddr), .arlen_m_inf(arlen), .arsize_m_inf(arsize),
      .arburst_m_inf(arburst), .arvalid_m_inf(arvalid), .arready_m_inf(arready),
      .rdata_m_inf(rdata), .rlast_m_inf(rlast), .rvalid_m_inf(rvalid), .rready_m_inf(rready)
   );

   // Arbitration rule at transaction level: who is granted given the pending request set.
   function automatic int pick_winner(input logic [1:0] r);
`ifdef RDARB_FIXED_PRIO_EN
      return r[0] ? 0 : 1;
`else
      if (r == 2'b11) return 1 - model_last_grant;
      return r[0] ? 0 : 1;
`endif
   endfunction

   task automatic set_client(input int c, input logic [AW-1:0] a, input logic [6:0] l);
      cl_addr[c] = a;
      cl_len[c]  = l;
      req_addr[c*AW +: AW] = a;
      req_len[c*7 +: 7]    = l;
      req[c] = 1'b1;
   endtask

   // Entered and left at a falling edge. Acts as the AXI slave for one burst owned by client c.
   task automatic serve_burst(input int c, input int ar_delay, input int max_gap,
                              input int late_beat, input int abort_beat, output int waited);
      logic [DW-1:0] d;
      int w;
      waited = -1;
      for (w = 0; w < 40; w++) begin
         #1;
         if (arvalid === 1'b1) break;
         @(negedge clk);
      end
      n_checks++;
      if (w >= 40) begin
         n_errors++;
         $display("FAIL ar_timeout client=%0d: arvalid stayed low for 40 cycles, required high", c);
         req[c] = 1'b0;
         return;
      end
      waited = w;
      n_checks++;
      if (arid !== IW'(c) || araddr !== cl_addr[c] || arlen !== cl_len[c] ||
          arsize !== 3'b001 || arburst !== 2'b01 || req_ack !== 2'b00) begin
         n_errors++;
         $display("FAIL ar_fields: got id=%0d addr=%h len=%0d size=%0d burst=%0d ack=%b, required id=%0d addr=%h len=%0d size=1 burst=1 ack=00",
                  arid, araddr, arlen, arsize, arburst, req_ack, c, cl_addr[c], cl_len[c]);
      end
      for (int k = 0; k < ar_delay; k++) begin
         @(negedge clk);
         #1;
         n_checks++;
         if (arvalid !== 1'b1 || araddr !== cl_addr[c] || arlen !== cl_len[c] || req_ack !== 2'b00) begin
            n_errors++;
            $display("FAIL ar_backpressure cycle %0d: got valid=%b addr=%h len=%0d ack=%b, required valid=1 addr=%h len=%0d ack=00",
                     k, arvalid, araddr, arlen, req_ack, cl_addr[c], cl_len[c]);
         end
      end
      arready = 1'b1;
      #1;
      n_checks++;
      if (req_ack !== 2'(1 << c)) begin
         n_errors++;
         $display("FAIL req_ack: got %b, required %b", req_ack, 2'(1 << c));
      end
      @(negedge clk);
      arready = 1'b0;
      req[c]  = 1'b0;
      for (int i = 0; i <= int'(cl_len[c]); i++) begin
         repeat ($urandom_range(max_gap, 0)) begin
            rvalid = 1'b0;
            rlast  = 1'b0;
            rdata  = DW'($urandom);
            #1;
            n_checks++;
            if (rsp_valid !== 2'b00 || rready !== 1'b1 || arvalid !== 1'b0) begin
               n_errors++;
               $display("FAIL beat_gap: got rsp_valid=%b rready=%b arvalid=%b, required 00/1/0",
                        rsp_valid, rready, arvalid);
            end
            @(negedge clk);
         end
         if (i == late_beat) req[1] = 1'b1;
         d      = DW'($urandom);
         rvalid = 1'b1;
         rdata  = d;
         rlast  = (i == int'(cl_len[c]));
         if (i == abort_beat) begin
            rst_n = 1'b0;
            #1;
            n_checks++;
            if (arvalid !== 1'b0 || rready !== 1'b0 || rsp_valid !== 2'b00) begin
               n_errors++;
               $display("FAIL reset_midburst: got arvalid=%b rready=%b rsp_valid=%b, required 0/0/00",
                        arvalid, rready, rsp_valid);
            end
            rvalid = 1'b0;
            rlast  = 1'b0;
            model_last_grant = 1;
            return;
         end
         #1;
         n_checks++;
         if (rsp_valid !== 2'(1 << c) || rsp_data !== d || rsp_last !== rlast ||
             rready !== 1'b1 || arvalid !== 1'b0) begin
            n_errors++;
            $display("FAIL beat %0d client %0d: got rsp_valid=%b data=%h last=%b rready=%b arvalid=%b, required %b/%h/%b/1/0",
                     i, c, rsp_valid, rsp_data, rsp_last, rready, arvalid, 2'(1 << c), d, rlast);
         end
         @(negedge clk);
      end
      rvalid = 1'b0;
      rlast  = 1'b0;
`ifndef RDARB_FIXED_PRIO_EN
      model_last_grant = c;
`endif
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      req = 2'b00;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_last_grant = 1;
      @(negedge clk);
   endtask

   task automatic check_wait(input string name, input int got);
      // Wait from entry (a falling edge right after req rose or after the rlast beat) to arvalid.
      n_checks++;
      if (got !== 1) begin
         n_errors++;
         $display("FAIL %s: arvalid after %0d cycles, required 1", name, got);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      rvalid = 1'b1;
      rlast  = 1'b1;
      rdata  = 16'hA5A5;
      #1;
      n_checks++;
      if (arvalid !== 1'b0 || araddr !== '0 || arlen !== '0 || arid !== '0 || rready !== 1'b0 ||
          req_ack !== 2'b00 || rsp_valid !== 2'b00 || rsp_last !== 1'b0 || rsp_data !== 16'hA5A5 ||
          arsize !== 3'b001 || arburst !== 2'b01) begin
         n_errors++;
         $display("FAIL reset_values: got arvalid=%b addr=%h len=%0d id=%0d rready=%b ack=%b rsp_valid=%b last=%b data=%h",
                  arvalid, araddr, arlen, arid, rready, req_ack, rsp_valid, rsp_last, rsp_data);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      n_checks++;
      if (rsp_valid !== 2'b00 || rsp_last !== 1'b0 || rready !== 1'b0 || arvalid !== 1'b0) begin
         n_errors++;
         $display("FAIL idle_ignores_r: got rsp_valid=%b last=%b rready=%b arvalid=%b, required 00/0/0/0",
                  rsp_valid, rsp_last, rready, arvalid);
      end
      rvalid = 1'b0;
      rlast  = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single();
      int w;
      set_client(0, 32'h0000_1000, 7'd7);
      serve_burst(0, 0, 0, -1, -1, w);
      check_wait("single_latency", w);
   endtask

   task automatic test_arbitration();
      int w;
      int first;
      apply_reset();
      set_client(0, 32'h0000_2000, 7'd3);
      set_client(1, 32'h0000_3000, 7'd2);
      serve_burst(0, 0, 0, -1, -1, w);
      serve_burst(1, 0, 0, -1, -1, w);
      check_wait("rr_turnaround", w);
      set_client(0, 32'h0000_2100, 7'd1);
      set_client(1, 32'h0000_3100, 7'd1);
      serve_burst(0, 0, 0, -1, -1, w);
      serve_burst(1, 0, 0, -1, -1, w);
      // After a lone fetch, a tie goes to load under round-robin and to fetch under fixed priority.
      set_client(0, 32'h0000_2200, 7'd0);
      serve_burst(0, 0, 0, -1, -1, w);
      set_client(0, 32'h0000_2300, 7'd1);
      set_client(1, 32'h0000_3300, 7'd1);
`ifdef RDARB_FIXED_PRIO_EN
      first = 0;
`else
      first = 1;
`endif
      serve_burst(first, 0, 0, -1, -1, w);
      serve_burst(1 - first, 0, 0, -1, -1, w);
   endtask

   task automatic test_request_during_burst();
      int w;
      set_client(0, 32'h0000_4000, 7'd7);
      cl_addr[1] = 32'h0000_5000;
      cl_len[1]  = 7'd4;
      req_addr[AW +: AW] = cl_addr[1];
      req_len[7 +: 7]    = cl_len[1];
      serve_burst(0, 0, 1, 3, -1, w);
      serve_burst(1, 0, 0, -1, -1, w);
      check_wait("busy_turnaround", w);
   endtask

   task automatic test_backpressure();
      int w;
      set_client(1, 32'h0000_6004, 7'd3);
      serve_burst(1, 5, 0, -1, -1, w);
   endtask

   task automatic test_single_beat_gapped();
      int w;
      set_client(0, 32'h0000_7000, 7'd0);
      serve_burst(0, 0, 0, -1, -1, w);
      set_client(1, 32'h0000_8000, 7'd7);
      serve_burst(1, 0, 3, -1, -1, w);
      check_wait("after_single_beat", w);
   endtask

   task automatic test_reset_midburst();
      int w;
      set_client(0, 32'h0000_9000, 7'd7);
      serve_burst(0, 0, 0, -1, 2, w);
      @(negedge clk);
      req = 2'b00;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      set_client(1, 32'h0000_A000, 7'd2);
      serve_burst(1, 0, 0, -1, -1, w);
   endtask

   task automatic test_random();
      int w;
      int c;
      logic [1:0] r;
      for (int it = 0; it < 10; it++) begin
         r = 2'($urandom_range(3, 1));
         for (int k = 0; k < 2; k++)
            if (r[k]) set_client(k, $urandom & 32'hFFFF_FFFE, 7'($urandom_range(15, 0)));
         for (int n = 0; n < 2 && req != 2'b00; n++) begin
            c = pick_winner(req);
            serve_burst(c, $urandom_range(3, 0), $urandom_range(2, 0), -1, -1, w);
         end
      end
   endtask

   initial begin
      req = 2'b00;
      req_addr = '0;
      req_len = '0;
      arready = 1'b0;
      rdata = '0;
      rlast = 1'b0;
      rvalid = 1'b0;
      model_last_grant = 1;
      @(negedge clk);
      test_reset();
      test_single();
      test_arbitration();
      test_request_during_burst();
      test_backpressure();
      test_single_beat_gapped();
      test_reset_midburst();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end
endmodule
